// File: rtl/ahb_pkg.sv
// Shared AHB-lite encodings, arbiter FSM states and the transfer alignment check.
package ahb_pkg;

   localparam logic [1:0] IDLE   = 2'b00;
   localparam logic [1:0] BUSY   = 2'b01;
   localparam logic [1:0] NONSEQ = 2'b10;
   localparam logic [1:0] SEQ    = 2'b11;

   localparam logic [2:0] BYTE     = 3'b000;
   localparam logic [2:0] HALFWORD = 3'b001;
   localparam logic [2:0] WORD     = 3'b010;

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

   // Sizes above WORD are unsupported on a 32-bit bus and report as misaligned.
   function automatic logic is_aligned(input logic [2:0] size, input logic [1:0] addr);
      case (size)
         BYTE:     return 1'b1;
         HALFWORD: return ~addr[0];
         WORD:     return (addr == 2'b00);
         default:  return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request after the last winner, wrapping.
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned IDX_W   = 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   idx
);

   logic             found;
   logic [IDX_W-1:0] k;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      k     = '0;
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
         k = IDX_W'((32'(ptr) + i) % NUM_REQ);
         if (!found && req[k]) begin
            found    = 1'b1;
            grant[k] = 1'b1;
            idx      = k;
         end
      end
   end

endmodule

// File: rtl/ahb_lite_master_arbiter.sv
// Sole AHB-lite master: grants local requesters round-robin and runs one
// single-beat NONSEQ transfer per grant, returning status to the winner.
module ahb_lite_master_arbiter
   import ahb_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 2,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic                          i_hclk,
   input  logic                          i_hresetn,
   input  logic [NUM_REQ-1:0]            i_req,
   input  logic [NUM_REQ-1:0]            i_req_write,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
   input  logic [NUM_REQ*3-1:0]          i_req_size,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_wdata,
   output logic [NUM_REQ-1:0]            o_ack,
   output logic                          o_err,
   output logic [DATA_WIDTH-1:0]         o_rdata,
   output logic [$clog2(NUM_REQ)-1:0]    o_owner,
   output logic                          o_timeout,
   output logic [ADDR_WIDTH-1:0]         o_haddr,
   output logic                          o_hwrite,
   output logic [2:0]                    o_hsize,
   output logic [1:0]                    o_htrans,
   output logic [DATA_WIDTH-1:0]         o_hwdata,
   input  logic                          i_hready,
   input  logic                          i_hresp,
   input  logic [DATA_WIDTH-1:0]         i_hrdata
);

   localparam int unsigned IDX_W  = $clog2(NUM_REQ);
   localparam int unsigned WAIT_W = 8;

   // Unpacked views of the per-requester request buses.
   logic [ADDR_WIDTH-1:0] addr_a  [NUM_REQ];
   logic [2:0]            size_a  [NUM_REQ];
   logic [DATA_WIDTH-1:0] wdata_a [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign addr_a[g]  = i_req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
      assign size_a[g]  = i_req_size[g*3 +: 3];
      assign wdata_a[g] = i_req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
   end

   logic [NUM_REQ-1:0] gnt;
   logic [IDX_W-1:0]   gnt_idx;

   state_t                state_q, state_d;
   logic [IDX_W-1:0]      ptr_q, ptr_d;
   logic [WAIT_W-1:0]     wait_q, wait_d;
   logic                  err_pend_q, err_pend_d;
   logic                  wr_q, wr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] rcap_q, rcap_d;

   logic [NUM_REQ-1:0]    ack_d;
   logic                  err_d;
   logic [DATA_WIDTH-1:0] rdata_d;
   logic [IDX_W-1:0]      owner_d;
   logic                  timeout_d;
   logic [ADDR_WIDTH-1:0] haddr_d;
   logic                  hwrite_d;
   logic [2:0]            hsize_d;
   logic [1:0]            htrans_d;
   logic [DATA_WIDTH-1:0] hwdata_d;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_arbiter (
      .req   (i_req),
      .ptr   (ptr_q),
      .grant (gnt),
      .idx   (gnt_idx)
   );

   // Pointer resets to the last index so requester 0 wins first.
   always_ff @(posedge i_hclk or negedge i_hresetn) begin
      if (!i_hresetn) begin
         state_q    <= S_IDLE;
         ptr_q      <= IDX_W'(NUM_REQ - 1);
         wait_q     <= '0;
         err_pend_q <= 1'b0;
         wr_q       <= 1'b0;
         wdata_q    <= '0;
         rcap_q     <= '0;
         o_ack      <= '0;
         o_err      <= 1'b0;
         o_rdata    <= '0;
         o_owner    <= '0;
         o_timeout  <= 1'b0;
         o_haddr    <= '0;
         o_hwrite   <= 1'b0;
         o_hsize    <= '0;
         o_htrans   <= IDLE;
         o_hwdata   <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         wait_q     <= wait_d;
         err_pend_q <= err_pend_d;
         wr_q       <= wr_d;
         wdata_q    <= wdata_d;
         rcap_q     <= rcap_d;
         o_ack      <= ack_d;
         o_err      <= err_d;
         o_rdata    <= rdata_d;
         o_owner    <= owner_d;
         o_timeout  <= timeout_d;
         o_haddr    <= haddr_d;
         o_hwrite   <= hwrite_d;
         o_hsize    <= hsize_d;
         o_htrans   <= htrans_d;
         o_hwdata   <= hwdata_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      wait_d     = wait_q;
      err_pend_d = err_pend_q;
      wr_d       = wr_q;
      wdata_d    = wdata_q;
      rcap_d     = rcap_q;
      ack_d      = '0;
      err_d      = 1'b0;
      rdata_d    = o_rdata;
      owner_d    = o_owner;
      timeout_d  = o_timeout;
      haddr_d    = o_haddr;
      hwrite_d   = o_hwrite;
      hsize_d    = o_hsize;
      htrans_d   = o_htrans;
      hwdata_d   = o_hwdata;

      case (state_q)
         S_IDLE: begin
            if (|gnt) begin
               owner_d = gnt_idx;
               wr_d    = i_req_write[gnt_idx];
               wdata_d = wdata_a[gnt_idx];
               if (!is_aligned(size_a[gnt_idx], addr_a[gnt_idx][1:0])) begin
                  err_pend_d = 1'b1;
                  state_d    = S_RESP;
               end else begin
                  err_pend_d = 1'b0;
                  htrans_d   = NONSEQ;
                  haddr_d    = addr_a[gnt_idx];
                  hwrite_d   = i_req_write[gnt_idx];
                  hsize_d    = size_a[gnt_idx];
                  state_d    = S_ADDR;
               end
            end
         end
         S_ADDR: begin
            if (i_hready) begin
               htrans_d = IDLE;
               if (wr_q) begin
                  hwdata_d = wdata_q;
               end
               wait_d  = '0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            // ERROR's first cycle arrives with hready low; the response is taken on the ready edge.
            if (i_hready) begin
               rcap_d     = i_hrdata;
               err_pend_d = i_hresp;
               state_d    = S_RESP;
            end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
               timeout_d  = 1'b1;
               err_pend_d = 1'b1;
               state_d    = S_RESP;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         S_RESP: begin
            ack_d[o_owner] = 1'b1;
            err_d          = err_pend_q;
            rdata_d        = (wr_q || err_pend_q) ? '0 : rcap_q;
            ptr_d          = o_owner;
            state_d        = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule
